// File: rtl/psum_accum_buffer_if.sv
// Stream interface between the last DP row, the partial-sum accumulator and writeback.
// master: upstream/drain side; slave: the accumulator buffer.
interface psum_accum_buffer_if #(
    parameter int unsigned col     = 4,
    parameter int unsigned psum_bw = 20,
    parameter int unsigned acc_bw  = 24
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_first;
    logic                    in_last;
    logic [col*psum_bw-1:0]  psum_in_flat;
    logic                    out_valid;
    logic                    out_ready;
    logic [col*acc_bw-1:0]   out_data_flat;

    modport master (
        output in_valid, in_first, in_last, psum_in_flat, out_ready,
        input  in_ready, out_valid, out_data_flat
    );

    modport slave (
        input  in_valid, in_first, in_last, psum_in_flat, out_ready,
        output in_ready, out_valid, out_data_flat
    );
endinterface

// File: rtl/psum_accum_buffer.sv
// Partial-sum accumulator: sums K-tile passes per output row with signed saturation and
// pushes finished rows into a small valid/ready output FIFO with a registered head.
module psum_accum_buffer #(
    parameter int unsigned col        = 4,
    parameter int unsigned psum_bw    = 20,
    parameter int unsigned acc_bw     = 24,
    parameter int unsigned rows       = 8,
    parameter int unsigned fifo_depth = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [$clog2(rows):0]   cfg_rows,
    psum_accum_buffer_if.slave      bus,
    output logic [$clog2(rows)-1:0] row_idx,
    output logic [col-1:0]          ovf
);
    localparam int unsigned riw   = $clog2(rows);
    localparam int unsigned ptr_w = $clog2(fifo_depth);
    localparam int unsigned cnt_w = ptr_w + 1;

    localparam logic signed [acc_bw-1:0] acc_max = {1'b0, {(acc_bw-1){1'b1}}};
    localparam logic signed [acc_bw-1:0] acc_min = {1'b1, {(acc_bw-1){1'b0}}};

    // Accumulator row buffer: no reset, upstream restarts every pass with in_first.
    logic [col*acc_bw-1:0] acc_q [rows];
    logic [col*acc_bw-1:0] mem_q [fifo_depth];

    logic [riw-1:0]        row_idx_q, row_idx_d;
    logic [riw:0]          row_lim;
    logic [ptr_w-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0]      count_q, count_d, remain;
    logic [col*acc_bw-1:0] head_q, head_d;
    logic [col-1:0]        ovf_q, ovf_d;

    logic                  accept, push, pop;
    logic [col*acc_bw-1:0] cur_vec, new_vec;
    logic [col-1:0]        sat_hit;

    logic signed [psum_bw-1:0] p_lane;
    logic signed [acc_bw-1:0]  s_lane, a_lane, n_lane;
    logic signed [acc_bw:0]    sum_lane;

    assign bus.in_ready      = (count_q != cnt_w'(fifo_depth));
    assign bus.out_valid     = (count_q != '0);
    assign bus.out_data_flat = head_q;
    assign row_idx           = row_idx_q;
    assign ovf               = ovf_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign push   = accept & bus.in_last;
    assign pop    = bus.out_valid & bus.out_ready;

    // Per-lane overwrite or saturating accumulate against the current row.
    always_comb begin
        new_vec  = '0;
        sat_hit  = '0;
        p_lane   = '0;
        s_lane   = '0;
        a_lane   = '0;
        n_lane   = '0;
        sum_lane = '0;
        cur_vec  = acc_q[row_idx_q];
        for (int i = 0; i < int'(col); i++) begin
            p_lane   = bus.psum_in_flat[i*psum_bw +: psum_bw];
            s_lane   = acc_bw'(p_lane);
            a_lane   = cur_vec[i*acc_bw +: acc_bw];
            // One guard bit: overflow shows up as the top two bits disagreeing.
            sum_lane = (acc_bw+1)'(a_lane) + (acc_bw+1)'(s_lane);
            if (bus.in_first) begin
                n_lane = s_lane;
            end else if (sum_lane[acc_bw] != sum_lane[acc_bw-1]) begin
                n_lane     = sum_lane[acc_bw] ? acc_min : acc_max;
                sat_hit[i] = 1'b1;
            end else begin
                n_lane = sum_lane[acc_bw-1:0];
            end
            new_vec[i*acc_bw +: acc_bw] = n_lane;
        end
    end

    // Row counter wraps at the configured pass length; 0 means the full buffer.
    always_comb begin
        row_lim   = (cfg_rows == '0) ? (riw+1)'(rows - 1) : cfg_rows - (riw+1)'(1);
        row_idx_d = row_idx_q;
        if (accept) begin
            row_idx_d = ({1'b0, row_idx_q} == row_lim) ? '0 : row_idx_q + riw'(1);
        end
    end

    // FIFO pointer/count update and next registered head.
    always_comb begin
        wr_ptr_d = wr_ptr_q + ptr_w'(push);
        rd_ptr_d = rd_ptr_q + ptr_w'(pop);
        count_d  = count_q + cnt_w'(push) - cnt_w'(pop);
        remain   = count_q - cnt_w'(pop);
        head_d   = head_q;
        if (count_d != '0) begin
            // A push into an otherwise empty queue bypasses storage into the head.
            head_d = (push && remain == '0) ? new_vec : mem_q[rd_ptr_d];
        end
        ovf_d = ovf_q | (accept ? sat_hit : '0);
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_idx_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
            ovf_q     <= '0;
        end else begin
            row_idx_q <= row_idx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            ovf_q     <= ovf_d;
        end
    end

    // Data storage: accumulator rows and FIFO slots, written only on accept/push.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_q[row_idx_q] <= new_vec;
        end
        if (push) begin
            mem_q[wr_ptr_q] <= new_vec;
        end
    end
endmodule
